// File: rtl/panel_display_scanner.sv
// rtl/panel_display_scanner.sv - multiplexed seven-segment scanner with frame-synchronous shadow loading
//
// Purpose:
//   Drives NUM_DIGITS multiplexed seven-segment digits in turn. Each digit is
//   lit for REFRESH_DIV clocks. A load goes into shadow registers first. The
//   display registers take the shadow only at the frame boundary, so a frame
//   never mixes old and new data.
//
// Ports:
//   clock      - sole clock; all state changes on the rising edge
//   reset      - asynchronous active-high reset
//   load       - one-cycle strobe that captures value, octal_mode and dp_mask
//   value      - number to display; digit 0 is least significant
//   octal_mode - 1: 3 bits per digit, 0: 4 bits per digit (hex)
//   dp_mask    - bit i = 1 lights the decimal point of digit i
//   pending    - shadow data is waiting for the next frame boundary
//   frame_tick - one-cycle pulse in the cycle where the digit index is back at 0
//   an         - anode enables, active-low
//   seg        - segments g..a in bits 6..0, active-low
//   dp         - decimal point, active-low
//
// Build option:
//   PANEL_LZ_BLANK_EN - when defined, digits above the highest nonzero digit
//                       are blanked; digit 0 is always shown.

module panel_display_scanner #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int VALUE_W     = 4 * NUM_DIGITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  octal_mode,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic                  pending,
  output logic                  frame_tick,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int NIB_W   = 4 * NUM_DIGITS;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [PRESC_W-1:0]    presc_q,      presc_d;
  logic [IDX_W-1:0]      idx_q,        idx_d;
  logic                  frame_tick_q, frame_tick_d;
  logic                  pending_q,    pending_d;
  logic [VALUE_W-1:0]    shadow_val_q, shadow_val_d;
  logic                  shadow_oct_q, shadow_oct_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q,  shadow_dp_d;
  logic [VALUE_W-1:0]    disp_val_q,   disp_val_d;
  logic                  disp_oct_q,   disp_oct_d;
  logic [NUM_DIGITS-1:0] disp_dp_q,    disp_dp_d;
  logic [NUM_DIGITS-1:0] an_q,         an_d;
  logic [6:0]            seg_q,        seg_d;
  logic                  dp_q,         dp_d;

  logic                  presc_tc;
  logic                  wrap;
  logic [NIB_W-1:0]      disp_ext;
  logic [3:0]            digit_nib [NUM_DIGITS];
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // Digit slices index into a value padded to a full hex width so that
  // digits beyond VALUE_W read as zero.
  generate
    if (VALUE_W >= NIB_W) begin : g_ext_trunc
      assign disp_ext = disp_val_q[NIB_W-1:0];
    end else begin : g_ext_pad
      assign disp_ext = {{(NIB_W - VALUE_W){1'b0}}, disp_val_q};
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_nib[i] = disp_oct_q ? {1'b0, disp_ext[3*i +: 3]} : disp_ext[4*i +: 4];
    end
  end

  always_comb begin
    cur_nib = 4'd0;
    cur_dp  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib = digit_nib[i];
        cur_dp  = disp_dp_q[i];
      end
    end
  end

`ifdef PANEL_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] keep;
  logic                  seen_nz;

  // Scan from the top digit down; once a nonzero digit is seen every lower
  // digit is kept.
  always_comb begin
    seen_nz = 1'b0;
    keep    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen_nz = seen_nz | (digit_nib[i] != 4'd0);
      keep[i] = seen_nz | (i == 0);
    end
  end

  always_comb begin
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_blank = ~keep[i];
      end
    end
  end
`else
  assign cur_blank = 1'b0;
`endif

  always_comb begin
    presc_tc     = (presc_q == PRESC_LAST);
    wrap         = presc_tc && (idx_q == IDX_LAST);
    presc_d      = presc_tc ? '0 : presc_q + 1'b1;
    idx_d        = idx_q;
    if (presc_tc) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    frame_tick_d = wrap;

    // Older shadow is committed at the boundary before a coincident load
    // overwrites the shadow, so the new data waits one more frame.
    disp_val_d   = disp_val_q;
    disp_oct_d   = disp_oct_q;
    disp_dp_d    = disp_dp_q;
    pending_d    = pending_q;
    if (wrap && pending_q) begin
      disp_val_d = shadow_val_q;
      disp_oct_d = shadow_oct_q;
      disp_dp_d  = shadow_dp_q;
      pending_d  = 1'b0;
    end

    shadow_val_d = shadow_val_q;
    shadow_oct_d = shadow_oct_q;
    shadow_dp_d  = shadow_dp_q;
    if (load) begin
      shadow_val_d = value;
      shadow_oct_d = octal_mode;
      shadow_dp_d  = dp_mask;
      pending_d    = 1'b1;
    end

    an_d  = ~(NUM_DIGITS'(1) << idx_q);
    seg_d = seg7(cur_nib);
    dp_d  = ~cur_dp;
    if (cur_blank) begin
      an_d  = '1;
      seg_d = 7'b1111111;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      frame_tick_q <= 1'b0;
      pending_q    <= 1'b0;
      shadow_val_q <= '0;
      shadow_oct_q <= 1'b0;
      shadow_dp_q  <= '0;
      disp_val_q   <= '0;
      disp_oct_q   <= 1'b0;
      disp_dp_q    <= '0;
      an_q         <= '1;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      frame_tick_q <= frame_tick_d;
      pending_q    <= pending_d;
      shadow_val_q <= shadow_val_d;
      shadow_oct_q <= shadow_oct_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_val_q   <= disp_val_d;
      disp_oct_q   <= disp_oct_d;
      disp_dp_q    <= disp_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;

endmodule

// File: tb/tb_panel_display_scanner.sv
// tb/tb_panel_display_scanner.sv - directed self-checking bench for panel_display_scanner (4 digits, divide by 4)
//
// Purpose:
//   Drives a linear sequence of directed steps and compares the outputs with
//   hand-computed values. Honours PANEL_LZ_BLANK_EN when it is defined.
// Ports: none (top-level bench).

module tb_panel_display_scanner;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        octal_mode = 1'b0;
  logic [3:0]  dp_mask = '0;
  logic        pending;
  logic        frame_tick;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;
  int e = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] SOFF = 7'b1111111;

  panel_display_scanner #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4),
    .VALUE_W    (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .value     (value),
    .octal_mode(octal_mode),
    .dp_mask   (dp_mask),
    .pending   (pending),
    .frame_tick(frame_tick),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clock = ~clock;

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    e++;
  endtask

  task automatic run_to(input int t);
    while (e < t) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic oct, input logic [3:0] m);
    value      = v;
    octal_mode = oct;
    dp_mask    = m;
    load       = 1'b1;
    tick();
    load       = 1'b0;
  endtask

  task automatic check_digit(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
    check({tag, "_an"}, 32'(an), 32'(exp_an));
    check({tag, "_seg"}, 32'(seg), 32'(exp_seg));
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'(SOFF));
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_ft", 32'(frame_tick), 32'h0);
    reset = 1'b0;
    e = 0;

    // Scan after reset release
    run_to(1);
    check_digit("scan_e1", 4'b1110, S0);
    check("scan_e1_dp", 32'(dp), 32'h1);
    check("scan_e1_ft", 32'(frame_tick), 32'h0);
    run_to(4);
    check("scan_e4_an", 32'(an), 32'b1110);
    run_to(5);
    check("scan_e5_an", 32'(an), 32'b1101);
    run_to(9);
    check("scan_e9_an", 32'(an), 32'b1011);
    run_to(13);
    check("scan_e13_an", 32'(an), 32'b0111);
    run_to(15);
    check("scan_e15_ft", 32'(frame_tick), 32'h0);
    run_to(16);
    check("scan_e16_ft", 32'(frame_tick), 32'h1);
    run_to(17);
    check("scan_e17_ft", 32'(frame_tick), 32'h0);
    check("scan_e17_an", 32'(an), 32'b1110);

    // Hex load mid-frame, committed at edge 32
    run_to(18);
    do_load(16'h1A7F, 1'b0, 4'b0010);
    check("hex_pend_set", 32'(pending), 32'h1);
    run_to(31);
    check("hex_pend_hold", 32'(pending), 32'h1);
    check("hex_no_tear", 32'(seg), 32'(S0));
    run_to(32);
    check("hex_pend_clr", 32'(pending), 32'h0);
    check("hex_ft", 32'(frame_tick), 32'h1);
    run_to(33);
    check_digit("hex_d0", 4'b1110, SF);
    check("hex_d0_dp", 32'(dp), 32'h1);
    run_to(37);
    check_digit("hex_d1", 4'b1101, S7);
    check("hex_d1_dp", 32'(dp), 32'h0);
    run_to(41);
    check_digit("hex_d2", 4'b1011, SA);
    run_to(45);
    check_digit("hex_d3", 4'b0111, S1);

    // Octal mode, 0x0FFF -> 7,7,7,7
    run_to(50);
    do_load(16'h0FFF, 1'b1, 4'b0000);
    run_to(65);
    check_digit("oct_d0", 4'b1110, S7);
    check("oct_d0_dp", 32'(dp), 32'h1);
    run_to(69);
    check_digit("oct_d1", 4'b1101, S7);
    run_to(73);
    check_digit("oct_d2", 4'b1011, S7);
    run_to(77);
    check_digit("oct_d3", 4'b0111, S7);

    // Two loads in one frame: latest wins
    run_to(82);
    do_load(16'h1111, 1'b0, 4'b0000);
    run_to(84);
    do_load(16'h2222, 1'b0, 4'b0000);
    check("two_pend", 32'(pending), 32'h1);
    check("two_old_shown", 32'(seg), 32'(S7));
    run_to(97);
    check_digit("two_d0", 4'b1110, S2);
    run_to(101);
    check_digit("two_d1", 4'b1101, S2);
    run_to(105);
    check_digit("two_d2", 4'b1011, S2);
    run_to(109);
    check_digit("two_d3", 4'b0111, S2);

    // Load during the frame_tick cycle while 0x3333 was pending
    run_to(114);
    do_load(16'h3333, 1'b0, 4'b0000);
    run_to(128);
    check("coin_ft", 32'(frame_tick), 32'h1);
    check("coin_pend_clr", 32'(pending), 32'h0);
    do_load(16'h4444, 1'b0, 4'b0000);
    check("coin_pend_new", 32'(pending), 32'h1);
    check_digit("coin_d0", 4'b1110, S3);
    run_to(141);
    check_digit("coin_d3", 4'b0111, S3);
    run_to(145);
    check_digit("coin_next_d0", 4'b1110, S4);
    run_to(157);
    check_digit("coin_next_d3", 4'b0111, S4);

    // Load landing on the wrap edge itself while 0x5555 was pending
    run_to(149);
    do_load(16'h5555, 1'b0, 4'b0000);
    run_to(159);
    do_load(16'h6666, 1'b0, 4'b0000);
    check("edge_ft", 32'(frame_tick), 32'h1);
    check("edge_pend", 32'(pending), 32'h1);
    run_to(161);
    check_digit("edge_d0", 4'b1110, S5);
    run_to(173);
    check_digit("edge_d3", 4'b0111, S5);
    run_to(176);
    check("edge_pend_clr", 32'(pending), 32'h0);
    run_to(177);
    check_digit("edge_next_d0", 4'b1110, S6);

    // Leading zeros, value 0x0005
    run_to(179);
    do_load(16'h0005, 1'b0, 4'b0000);
    run_to(193);
    check_digit("lz_d0", 4'b1110, S5);
`ifdef PANEL_LZ_BLANK_EN
    run_to(197);
    check_digit("lz_d1", 4'b1111, SOFF);
    check("lz_d1_dp", 32'(dp), 32'h1);
    run_to(201);
    check_digit("lz_d2", 4'b1111, SOFF);
    run_to(205);
    check_digit("lz_d3", 4'b1111, SOFF);
`else
    run_to(197);
    check_digit("lz_d1", 4'b1101, S0);
    run_to(201);
    check_digit("lz_d2", 4'b1011, S0);
    run_to(205);
    check_digit("lz_d3", 4'b0111, S0);
`endif
    run_to(209);
    check_digit("lz_wrap_d0", 4'b1110, S5);

    // Reset mid-frame discards a pending load
    run_to(211);
    do_load(16'h7777, 1'b0, 4'b0000);
    check("mrst_pend_before", 32'(pending), 32'h1);
    run_to(214);
    #2;
    reset = 1'b1;
    #1;
    check("mrst_an", 32'(an), 32'hF);
    check("mrst_seg", 32'(seg), 32'(SOFF));
    check("mrst_dp", 32'(dp), 32'h1);
    check("mrst_pend", 32'(pending), 32'h0);
    check("mrst_ft", 32'(frame_tick), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    e = 0;
    run_to(1);
    check_digit("mrst_e1", 4'b1110, S0);
    run_to(16);
    check("mrst_ft16", 32'(frame_tick), 32'h1);
    check("mrst_pend16", 32'(pending), 32'h0);
    run_to(17);
    check_digit("mrst_e17", 4'b1110, S0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
